// File: rtl/imem_boot_controller.sv
// imem_boot_controller
//   Owns the single port of the SPRAM instruction memory. After reset it copies
//   BOOT_WORDS words from a synchronous boot ROM into SPRAM while holding off CPU
//   fetches. Once the copy is done it shares the port every cycle between a
//   program-loader write port (higher priority) and CPU instruction fetch.
//
// Ports
//   clk, rst                     rising-edge clock, asynchronous active-high reset
//   cpu_req/cpu_addr             CPU fetch request and word address
//   cpu_stall                    fetch not accepted this cycle (combinational)
//   cpu_rdata/cpu_rvalid         fetched word, valid the cycle after acceptance
//   ld_valid/ld_addr/ld_data     loader write request
//   ld_ready                     loader write accepted when ld_valid && ld_ready
//   rom_addr/rom_rdata           boot ROM port, 1-cycle read latency
//   mem_addr/mem_wr_en/mem_wdata SPRAM command
//   mem_rdata                    SPRAM read data, 1-cycle latency
//   boot_done                    high from the first RUN cycle until reset
module imem_boot_controller #(
    parameter int unsigned BOOT_WORDS = 4096,
    parameter int unsigned ROM_AW     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [13:0]       cpu_addr,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ld_valid,
    input  logic [13:0]       ld_addr,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_rdata,
    output logic [13:0]       mem_addr,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              boot_done
);

    typedef enum logic {StCopy, StRun} state_e;

    localparam logic [14:0] BootWordsW = 15'(BOOT_WORDS);
    localparam logic [13:0] LastAddr   = 14'(BOOT_WORDS - 1);

    state_e      state_q, state_d;
    logic [14:0] rd_ptr_q, rd_ptr_d;
    logic        wr_pend_q, wr_pend_d;
    logic [13:0] wr_addr_q, wr_addr_d;
    logic        cpu_rvalid_q, cpu_rvalid_d;

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_pend_d    = 1'b0;
        wr_addr_d    = wr_addr_q;
        cpu_rvalid_d = 1'b0;
        unique case (state_q)
            StCopy: begin
                // ROM read issued this cycle becomes the SPRAM write of the next one.
                if (rd_ptr_q < BootWordsW) begin
                    rd_ptr_d  = rd_ptr_q + 15'd1;
                    wr_pend_d = 1'b1;
                    wr_addr_d = rd_ptr_q[13:0];
                end
                if (wr_pend_q && (wr_addr_q == LastAddr)) begin
                    state_d   = StRun;
                    wr_pend_d = 1'b0;
                end
            end
            StRun: begin
                cpu_rvalid_d = cpu_req && !ld_valid;
            end
            default: state_d = StCopy;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StCopy;
            rd_ptr_q     <= 15'd0;
            wr_pend_q    <= 1'b0;
            wr_addr_q    <= 14'd0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_pend_q    <= wr_pend_d;
            wr_addr_q    <= wr_addr_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

    assign rom_addr   = rd_ptr_q[ROM_AW-1:0];
    assign ld_ready   = (state_q == StRun);
    assign boot_done  = (state_q == StRun);
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = mem_rdata;

    // SPRAM port mux: copy writes, then loader over CPU
    always_comb begin
        mem_wr_en = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = ld_data;
        cpu_stall = cpu_req;
        if (state_q == StCopy) begin
            mem_wr_en = wr_pend_q;
            mem_addr  = wr_addr_q;
            mem_wdata = rom_rdata;
        end else if (ld_valid) begin
            mem_wr_en = 1'b1;
            mem_addr  = ld_addr;
        end else begin
            cpu_stall = 1'b0;
        end
    end

endmodule
